// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one group-aligned icache request at a time and queues
// returned groups toward decode. Optional same-cycle bypass: define FETCH_QUEUE_BYPASS_EN.
//
// state  | meaning
// S_REQ  | ready to issue the next group request
// S_WAIT | request accepted, waiting for its response
// S_DROP | request accepted but redirected; its response will be discarded
module fetch_unit #(
    parameter int          FETCH_WIDTH = 4,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      icache_req_valid,
    input  logic                      icache_req_ready,
    output logic [31:0]               icache_req_pc,
    input  logic                      icache_resp_valid,
    input  logic [32*FETCH_WIDTH-1:0] icache_resp_inst,
    output logic                      fetch_valid,
    input  logic                      fetch_ready,
    output logic [31:0]               fetch_pc,
    output logic [32*FETCH_WIDTH-1:0] fetch_inst,
    output logic [FETCH_WIDTH-1:0]    fetch_mask
);
    localparam int          IW          = 32 * FETCH_WIDTH;
    localparam int          PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int          CNT_W       = PTR_W + 1;
    localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);
    localparam logic [31:0] ALIGN_MASK  = ~(GROUP_BYTES - 32'd1);
    localparam logic [31:0] SLOT_MASK   = 32'(FETCH_WIDTH) - 32'd1;
    localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t             state;
    logic [31:0]        pc_q;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               run_q;

    logic [31:0]        q_pc   [QUEUE_DEPTH];
    logic [IW-1:0]      q_inst [QUEUE_DEPTH];
    logic [FETCH_WIDTH-1:0] q_mask [QUEUE_DEPTH];

    logic [31:0]        base_pc;
    logic [31:0]        slot_idx;
    logic [FETCH_WIDTH-1:0] new_mask;
    logic               q_empty;
    logic               q_full;
    logic               handshake;
    logic               take;
    logic               bypass;
    logic               push;
    logic               pop;
    logic               unused_bits;

    assign unused_bits = &{1'b0, redirect_pc[1:0]};

    always_comb begin
        base_pc  = pc_q & ALIGN_MASK;
        slot_idx = (pc_q >> 2) & SLOT_MASK;
        new_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            new_mask[i] = (32'(i) >= slot_idx);
        end
    end

    assign q_empty = (count == '0);
    assign q_full  = (count == DEPTH);

    // run_q keeps the request line low while (and just after) reset is asserted.
    assign icache_req_valid = run_q & (state == S_REQ) & ~q_full & ~redirect_valid;
    assign icache_req_pc    = base_pc;
    assign handshake        = icache_req_valid & icache_req_ready;
    assign take             = (state == S_WAIT) & icache_resp_valid & ~redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = take & q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign fetch_valid = ~q_empty | bypass;
    assign pop         = ~q_empty & fetch_ready & ~redirect_valid;
    assign push        = take & ~(bypass & fetch_ready);

    always_comb begin
        fetch_pc   = '0;
        fetch_inst = '0;
        fetch_mask = '0;
        if (!q_empty) begin
            fetch_pc   = q_pc[rd_ptr];
            fetch_inst = q_inst[rd_ptr];
            fetch_mask = q_mask[rd_ptr];
        end else if (bypass) begin
            fetch_pc   = base_pc;
            fetch_inst = icache_resp_inst;
            fetch_mask = new_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= base_pc;
            q_inst[wr_ptr] <= icache_resp_inst;
            q_mask[wr_ptr] <= new_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            pc_q   <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                pc_q   <= {redirect_pc[31:2], 2'b00};
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                // A response landing with the redirect retires the outstanding request.
                case (state)
                    S_WAIT:  state <= icache_resp_valid ? S_REQ : S_DROP;
                    S_DROP:  state <= icache_resp_valid ? S_REQ : S_DROP;
                    default: state <= S_REQ;
                endcase
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
                case (state)
                    S_REQ: begin
                        if (handshake) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (icache_resp_valid) begin
                            pc_q  <= base_pc + GROUP_BYTES;
                            state <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (icache_resp_valid) state <= S_REQ;
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, directed scenarios, then random traffic.
module tb_fetch_unit;
    localparam int          FW     = 4;
    localparam int          QD     = 4;
    localparam int          IW     = 32 * FW;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] GBYTES = 32'(4 * FW);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          icache_req_valid;
    logic          icache_req_ready = 1'b0;
    logic [31:0]   icache_req_pc;
    logic          icache_resp_valid = 1'b0;
    logic [IW-1:0] icache_resp_inst = '0;
    logic          fetch_valid;
    logic          fetch_ready = 1'b0;
    logic [31:0]   fetch_pc;
    logic [IW-1:0] fetch_inst;
    logic [FW-1:0] fetch_mask;

    always #5 clk = ~clk;

    fetch_unit #(.FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_pc(icache_req_pc),
        .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_inst(fetch_inst), .fetch_mask(fetch_mask)
    );

    typedef struct {
        logic [31:0]   pc;
        logic [IW-1:0] inst;
        logic [FW-1:0] mask;
    } grp_t;

    grp_t          q[$];
    logic [31:0]   m_pc;
    bit            m_out, m_drop, m_run;
    int            lat_cnt = -1;
    int            cur_lat = 1;
    logic [IW-1:0] pend_inst = '0;
    bit            e_req_valid, e_take, e_fv;
    grp_t          e_grp;
    int            checks = 0;
    int            passed = 0;
    logic [31:0]   req_log[$];
    logic [31:0]   head_pc_log[$];
    logic [FW-1:0] head_mask_log[$];

    function automatic logic [31:0] align(input logic [31:0] a);
        return a - (a % GBYTES);
    endfunction

    function automatic logic [FW-1:0] mask_of(input logic [31:0] a);
        logic [FW-1:0] m;
        int s;
        s = int'((a / 32'd4) % 32'(FW));
        m = '0;
        for (int i = 0; i < FW; i++) m[i] = (i >= s);
        return m;
    endfunction

    function automatic logic [IW-1:0] rand_inst();
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < FW; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Apply one cycle of inputs and compare every output against the model.
    task automatic drive(input bit redir, input logic [31:0] rpc, input bit rdy,
                         input bit frdy, input int lat, input bit spur);
        redirect_valid    = redir;
        redirect_pc       = rpc;
        icache_req_ready  = rdy;
        fetch_ready       = frdy;
        cur_lat           = lat;
        icache_resp_valid = (lat_cnt == 0) || (spur && !m_out);
        icache_resp_inst  = (lat_cnt == 0) ? pend_inst : rand_inst();
        #1;
        e_req_valid = m_run && !m_out && (q.size() < QD) && !redir;
        e_take      = m_out && !m_drop && icache_resp_valid && !redir;
        e_fv        = (q.size() > 0) || (BYP && e_take);
        if (q.size() > 0) e_grp = q[0];
        else e_grp = '{align(m_pc), icache_resp_inst, mask_of(m_pc)};
        chk("req_valid", IW'(icache_req_valid), IW'(e_req_valid));
        chk("req_pc", IW'(icache_req_pc), IW'(align(m_pc)));
        chk("fetch_valid", IW'(fetch_valid), IW'(e_fv));
        if (e_fv) begin
            chk("fetch_pc", IW'(fetch_pc), IW'(e_grp.pc));
            chk("fetch_inst", fetch_inst, e_grp.inst);
            chk("fetch_mask", IW'(fetch_mask), IW'(e_grp.mask));
        end
        if (icache_req_valid && rdy) req_log.push_back(icache_req_pc);
        if (fetch_valid && frdy) begin
            head_pc_log.push_back(fetch_pc);
            head_mask_log.push_back(fetch_mask);
        end
    endtask

    task automatic advance();
        int   had;
        bit   hs, consumed;
        grp_t g;
        @(posedge clk);
        hs  = e_req_valid && icache_req_ready;
        had = q.size();
        m_run = 1'b1;
        if (lat_cnt == 0) lat_cnt = -1;
        else if (lat_cnt > 0) lat_cnt--;
        if (redirect_valid) begin
            q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out) begin
                if (icache_resp_valid) begin
                    m_out = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (had > 0 && fetch_ready) g = q.pop_front();
            if (m_out && icache_resp_valid) begin
                if (!m_drop) begin
                    consumed = BYP && (had == 0) && fetch_ready;
                    if (!consumed) q.push_back('{align(m_pc), icache_resp_inst, mask_of(m_pc)});
                    m_pc = align(m_pc) + GBYTES;
                end
                m_out = 1'b0;
                m_drop = 1'b0;
            end
            if (hs) begin
                m_out = 1'b1;
                lat_cnt = cur_lat - 1;
                pend_inst = rand_inst();
            end
        end
        #1;
    endtask

    task automatic cyc(input bit redir, input logic [31:0] rpc, input bit rdy,
                       input bit frdy, input int lat, input bit spur);
        drive(redir, rpc, rdy, frdy, lat, spur);
        advance();
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", IW'(icache_req_valid), IW'(1'b0));
        chk("rst_fetch_valid", IW'(fetch_valid), IW'(1'b0));
        chk("rst_fetch_mask", IW'(fetch_mask), IW'(1'b0));
        redirect_valid = 1'b0;
        icache_req_ready = 1'b0;
        icache_resp_valid = 1'b0;
        fetch_ready = 1'b0;
        q.delete();
        m_pc = RST_PC;
        m_out = 1'b0;
        m_drop = 1'b0;
        m_run = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got;
        bit frdy_hi;

        // Sequential fetch from the reset vector.
        do_reset();
        req_log.delete(); head_pc_log.delete(); head_mask_log.delete();
        for (int i = 0; i < 9; i++) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        chk("t1_req_count", IW'(req_log.size() >= 3), IW'(1'b1));
        chk("t1_head_count", IW'(head_pc_log.size() >= 3), IW'(1'b1));
        if (req_log.size() >= 3 && head_pc_log.size() >= 3) begin
            chk("t1_req0", IW'(req_log[0]), IW'(32'hBFC0_0000));
            chk("t1_req1", IW'(req_log[1]), IW'(32'hBFC0_0010));
            chk("t1_req2", IW'(req_log[2]), IW'(32'hBFC0_0020));
            chk("t1_head0", IW'(head_pc_log[0]), IW'(32'hBFC0_0000));
            chk("t1_head2", IW'(head_pc_log[2]), IW'(32'hBFC0_0020));
            chk("t1_mask0", IW'(head_mask_log[0]), IW'(4'b1111));
        end

        // Redirect in S_REQ to a mid-group address.
        do_reset();
        req_log.delete();
        cyc(1'b1, 32'h8000_0008, 1'b1, 1'b0, 1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        chk("t2_head_pc", IW'(fetch_pc), IW'(32'h8000_0000));
        chk("t2_head_mask", IW'(fetch_mask), IW'(4'b1100));
        advance();
        chk("t2_req_count", IW'(req_log.size() >= 2), IW'(1'b1));
        if (req_log.size() >= 2) begin
            chk("t2_req0", IW'(req_log[0]), IW'(32'h8000_0000));
            chk("t2_req1", IW'(req_log[1]), IW'(32'h8000_0010));
        end

        // Fill the queue, then free one slot.
        for (int i = 0; i < 16; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        chk("t3_full_req_valid", IW'(icache_req_valid), IW'(1'b0));
        chk("t3_full_fetch_valid", IW'(fetch_valid), IW'(1'b1));
        advance();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1, 1'b0);
        chk("t3_req_valid_after_pop", IW'(icache_req_valid), IW'(1'b1));
        chk("t3_head_after_pop", IW'(fetch_pc), IW'(32'h8000_0010));
        advance();

        // Redirect while waiting; the late response must be dropped.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 4, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 4, 1'b0);
        cyc(1'b1, 32'h8000_1000, 1'b0, 1'b1, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b0);
            chk("t4_drop_fetch_valid", IW'(fetch_valid), IW'(1'b0));
            advance();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        chk("t4_req_valid", IW'(icache_req_valid), IW'(1'b1));
        chk("t4_req_pc", IW'(icache_req_pc), IW'(32'h8000_1000));
        advance();

        // Reset mid-S_WAIT with two groups queued.
        do_reset();
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 2, 1'b0);
            if (q.size() == 2 && m_out) got = 1;
        end
        chk("t5_setup_reached", IW'(got), IW'(1));
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        chk("t5_req_pc", IW'(icache_req_pc), IW'(32'hBFC0_0000));
        advance();
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);

        // Response-to-fetch_valid latency on an empty queue.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b0);
        chk("t6_resp_cycle_fetch_valid", IW'(fetch_valid), IW'(BYP));
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b0);
        chk("t6_next_cycle_fetch_valid", IW'(fetch_valid), IW'(!BYP));
        advance();

        // Random traffic with occasional redirects, stray responses and resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 699) == 0) do_reset();
            frdy_hi = ((c / 200) % 2) == 0;
            cyc($urandom_range(0, 11) == 0, $urandom(),
                $urandom_range(0, 9) < 7,
                frdy_hi ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2),
                $urandom_range(1, 4), $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised, sequential fetch stage.
- Owns the PC register and issues one group-aligned request at a time to the icache over a valid/ready handshake.
- Builds a per-slot valid mask for each returned group and buffers groups in a FIFO of QUEUE_DEPTH entries toward decode.
- Handles redirects: flushes the queue and discards any in-flight response. Sits between the branch/commit redirect source and decode.

Parameters:
FETCH_WIDTH, 4, instructions per fetch group; power of two, 1..8
QUEUE_DEPTH, 4, fetch-group FIFO entries; power of two, >=2
RESET_PC, 32'hBFC0_0000, PC loaded on reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  redirect request from backend
redirect_pc  in  32  redirect target; bits [1:0] ignored
icache_req_valid  out  1  request valid
icache_req_ready  in  1  icache accepts request
icache_req_pc  out  32  group-aligned address (low log2(FETCH_WIDTH)+2 bits zero)
icache_resp_valid  in  1  response valid, one cycle pulse, in order
icache_resp_inst  in  32*FETCH_WIDTH  instructions; slot i at bits [32i+31:32i]
fetch_valid  out  1  queue head valid
fetch_ready  in  1  decode consumes head
fetch_pc  out  32  group-aligned base PC of head; slot i PC = fetch_pc + 4i
fetch_inst  out  32*FETCH_WIDTH  head instructions
fetch_mask  out  FETCH_WIDTH  per-slot valid of head

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - pc_q=RESET_PC, state=S_REQ, queue count=0, rd/wr pointers=0, drop flag=0.
  - icache_req_valid=0, fetch_valid=0, fetch_mask=0, fetch_pc=0, fetch_inst=0.
- States:
  - S_REQ: icache_req_valid = (count<QUEUE_DEPTH) & !redirect_valid. Handshake (valid&ready) -> S_WAIT.
  - S_WAIT: awaiting response. On icache_resp_valid, push group and advance PC -> S_REQ.
  - S_DROP: awaiting a response that must be discarded. On icache_resp_valid, discard -> S_REQ.
- Request and push rules:
  - icache_req_pc = pc_q with low log2(FETCH_WIDTH)+2 bits cleared.
  - Pushed entry: base = aligned pc_q; mask bit i = (i >= pc_q[log2(FETCH_WIDTH)+1:2]); inst = icache_resp_inst.
  - After each push, pc_q <= aligned pc_q + 4*FETCH_WIDTH. 32-bit add, wraps modulo 2^32 with no special case.
- Queue:
  - Pop when fetch_valid & fetch_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Requests are issued only when count<QUEUE_DEPTH. At most one request is outstanding, so a push never overflows.
  - Without bypass, push-to-fetch_valid latency is one cycle.
- Redirect (redirect_valid=1), highest priority:
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - Queue cleared (count=0, pointers=0). A same-cycle pop or push is ignored; fetch_valid=0 next cycle.
  - State transitions: from S_WAIT -> S_DROP; in S_DROP -> stays in S_DROP; in S_REQ -> stays in S_REQ (no handshake possible, since req_valid is masked).
  - Redirect in S_WAIT coincident with icache_resp_valid: the response is discarded, state -> S_REQ.
  - Back-to-back redirects: the last value wins.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving before the first post-reset request handshake are ignored.
- icache_resp_valid in S_REQ is a protocol error and is ignored.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined:
  - When the queue is empty and a valid, non-dropped response arrives, fetch_valid/fetch_pc/fetch_inst/fetch_mask are driven combinationally from the response in that same cycle.
  - If fetch_ready=1 that cycle, the group is consumed and not written to the queue; otherwise it is written.
  - Redirect in that cycle suppresses the bypass (fetch_valid=0).
- Undefined: no bypass; fetch_valid asserts one cycle after the push.

Test Plan:
1. Reset release, icache_req_ready=1, response 1 cycle after each handshake, fetch_ready=1 -> req_pc 0xBFC00000, 0xBFC00010, 0xBFC00020; each head has fetch_mask=4'b1111 and fetch_pc matching its request.
2. Redirect to 0x80000008 in S_REQ -> next req_pc=0x80000000; pushed mask=4'b1100, fetch_pc=0x80000000; following req_pc=0x80000010.
3. fetch_ready=0, four responses -> count=4, icache_req_valid=0. One pop -> icache_req_valid=1 on the next cycle and the FIFO order is preserved.
4. Redirect to 0x80001000 while in S_WAIT, response arrives 3 cycles later -> response dropped, fetch_valid stays 0, next req_pc=0x80001000.
5. rst_n=0 asserted mid-S_WAIT with 2 queued groups -> fetch_valid=0 and icache_req_valid=0 immediately; after release req_pc=0xBFC00000.
6. With FETCH_QUEUE_BYPASS_EN, empty queue, fetch_ready=1 -> fetch_valid=1 in the response cycle and count stays 0. Without the macro -> fetch_valid=1 one cycle later.
